// File: rtl/uart_fwft_fifo_if.sv
// rtl/uart_fwft_fifo_if.sv - push/pop/status bundle for the UART first-word-fall-through FIFO
interface uart_fwft_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  flush;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  full;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_en;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, clr_err, wr_data, wr_en, rd_en,
        input  full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, wr_data, wr_en, rd_en,
        output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/uart_fwft_fifo.sv
// rtl/uart_fwft_fifo.sv - parametrised FWFT FIFO with occupancy, thresholds, sticky errors and flush
module uart_fwft_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    uart_fwft_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   ONE_P    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  full_w;
    logic                  empty_w;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_evt;
    logic                  udf_evt;
    logic [ADDR_WIDTH-1:0] head_next_addr;

    assign full_w         = (count_q == DEPTH_C);
    assign empty_w        = (count_q == '0);
    assign head_next_addr = rd_ptr[ADDR_WIDTH-1:0] + ONE_A;

    // Flush masks both requests and any error they would otherwise raise.
    always_comb begin
        wr_acc  = bus.wr_en & (~full_w | bus.rd_en) & ~bus.flush;
        rd_acc  = bus.rd_en & ~empty_w & ~bus.flush;
        ovf_evt = bus.wr_en & full_w & ~bus.rd_en & ~bus.flush;
        udf_evt = bus.rd_en & empty_w & ~bus.flush;
    end

    always_ff @(posedge CLK) begin
        if (wr_acc && !RST) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + ONE_P;
                2'b01:   count_q <= count_q - ONE_P;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head register: a word written into an empty (or draining-to-empty) FIFO
    // bypasses memory so it is visible one cycle after the write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_q <= '0;
        end else if (!bus.flush) begin
            if (wr_acc && (empty_w || (rd_acc && count_q == ONE_P))) begin
                rd_data_q <= bus.wr_data;
            end else if (rd_acc) begin
                rd_data_q <= mem[head_next_addr];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= ovf_evt | (overflow_q & ~bus.clr_err);
            underflow_q <= udf_evt | (underflow_q & ~bus.clr_err);
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_full  = (count_q >= AFULL_C);
    assign bus.almost_empty = (count_q <= AEMPTY_C);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_uart_fwft_fifo.sv
// tb/tb_uart_fwft_fifo.sv - self-checking bench for uart_fwft_fifo
module tb_uart_fwft_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    uart_fwft_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_fwft_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    typedef struct {
        bit            wr;
        logic [DW-1:0] wd;
        bit            rd;
        bit            ce;
        int            cnt;
        bit            emp;
        bit            udf;
        logic [DW-1:0] head;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = q.size();
        check({tag, " count"}, 32'(bus.count), n);
        check({tag, " empty"}, 32'(bus.empty), 32'(n == 0));
        check({tag, " full"}, 32'(bus.full), 32'(n == DEPTH));
        check({tag, " almost_full"}, 32'(bus.almost_full), 32'(n >= AF));
        check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(m_ovf));
        check({tag, " underflow"}, 32'(bus.underflow), 32'(m_udf));
        if (n > 0) check({tag, " rd_data"}, 32'(bus.rd_data), 32'(q[0]));
    endtask

    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd,
                        input bit fl, input bit ce, input string tag);
        int n;
        bit wacc;
        bit racc;
        n = q.size();
        if (rd && n > 0) check({tag, " pop"}, 32'(bus.rd_data), 32'(q[0]));
        bus.wr_en = wr; bus.wr_data = wd; bus.rd_en = rd; bus.flush = fl; bus.clr_err = ce;
        if (ce) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (fl) begin
            q.delete();
        end else begin
            wacc = wr && (n < DEPTH || rd);
            racc = rd && n > 0;
            if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
            if (rd && n == 0) m_udf = 1'b1;
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(wd);
        end
        @(posedge CLK); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        check_state(tag);
    endtask

    initial begin
        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'hA5};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'h3C};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 8'h3C};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b1, 8'h00};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 8'h00};

        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
        bus.wr_data = '0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("reset rd_data", 32'(bus.rd_data), 32'h0);
        check_state("reset");

        for (int i = 0; i < 10; i++) begin
            bus.wr_en = tbl[i].wr; bus.wr_data = tbl[i].wd;
            bus.rd_en = tbl[i].rd; bus.clr_err = tbl[i].ce;
            @(posedge CLK); #1;
            bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
            check($sformatf("vec%0d count", i), 32'(bus.count), tbl[i].cnt);
            check($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(tbl[i].emp));
            check($sformatf("vec%0d full", i), 32'(bus.full), 32'h0);
            check($sformatf("vec%0d almost_empty", i), 32'(bus.almost_empty), 32'(tbl[i].cnt <= AE));
            check($sformatf("vec%0d almost_full", i), 32'(bus.almost_full), 32'h0);
            check($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'h0);
            check($sformatf("vec%0d underflow", i), 32'(bus.underflow), 32'(tbl[i].udf));
            if (!tbl[i].emp)
                check($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(tbl[i].head));
        end

        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, $sformatf("fill%0d", i));
        check("full after 16", 32'(bus.full), 32'h1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "overfill");
        check("overflow set", 32'(bus.overflow), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("order%0d", i), 32'(bus.rd_data), i);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, $sformatf("drain%0d", i));
        end

        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, $sformatf("refill%0d", i));
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, "full_rw");
        check("full_rw head", 32'(bus.rd_data), 32'h11);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("tail word", 32'(bus.rd_data), 32'h77);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, $sformatf("wrapdrain%0d", i));
        end

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, $sformatf("pre_flush%0d", i));
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, "flush");
        check("flush keeps overflow", 32'(bus.overflow), 32'h1);

        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, $sformatf("pre_rst%0d", i));
        bus.wr_en = 1'b1; bus.wr_data = 8'h99; bus.rd_en = 1'b1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        check("midrst rd_data", 32'(bus.rd_data), 32'h0);
        check_state("midrst");

        for (int i = 0; i < 300; i++) begin
            bit wr, rd, fl, ce;
            wr = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 40) == 0);
            ce = ($urandom_range(0, 15) == 0);
            step(wr, 8'($urandom), rd, fl, ce, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_fwft_fifo.md
Name: uart_fwft_fifo

Overview:
Parametrised first-word-fall-through FIFO for UART TX/RX buffering. It is the successor to the fixed 8-deep UART FIFO.
It adds the following:
- occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- synchronous flush
It sits between the bus-side UART registers and the bit-serial TX/RX engines. One instance is used per direction.

Parameters:
DATA_WIDTH, 8, word width in bits.
ADDR_WIDTH, 4, log2 of depth (DEPTH = 2**ADDR_WIDTH = 16); legal range 1..10.
AFULL_THRESH, 12, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
AEMPTY_THRESH, 2, almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
flush  in  1  synchronous discard of all contents.
wr_data  in  DATA_WIDTH  write word.
wr_en  in  1  push request.
full  out  1  count == DEPTH.
almost_full  out  1  count >= AFULL_THRESH.
rd_data  out  DATA_WIDTH  head word; valid whenever empty == 0.
rd_en  in  1  pop request (acknowledges the current rd_data).
empty  out  1  count == 0.
almost_empty  out  1  count <= AEMPTY_THRESH.
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a write was attempted while full and not simultaneously popped.
underflow  out  1  sticky: a read was attempted while empty.
clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (RST=1 at edge):
  - pointers = 0, count = 0
  - empty = 1, full = 0, almost_full = 0
  - almost_empty = 1, overflow = 0, underflow = 0, rd_data = 0
  - Reset overrides every other input. Reset during streaming discards all data.
- Storage and pointers:
  - Pointers are ADDR_WIDTH+1 bits; the MSB disambiguates full from empty. Pointers wrap modulo 2*DEPTH.
  - Memory is written at wr_ptr[ADDR_WIDTH-1:0].
- Output timing:
  - All outputs are registered or decoded only from registered state. There is no combinational path from any input to any output.
- FWFT:
  - The head word is presented on rd_data without a read request.
  - A write into an empty FIFO at edge N gives empty = 0 and rd_data = that word after edge N. Write-to-visible latency is 1 cycle.
  - rd_en with empty = 0 pops at the edge. After the edge, rd_data = next entry, or empty = 1 if none remains.
- Accept rules, evaluated at each edge when RST = 0 and flush = 0:
  - Write accepted = wr_en & (!full | rd_en). Read accepted = rd_en & !empty.
  - Full, wr_en and rd_en together: both are accepted, count is unchanged, and the new word goes to the tail.
  - Empty, wr_en and rd_en together: the read is rejected and underflow is set. The write is accepted, count = 1, and rd_data = wr_data after the edge.
  - Rejected write (wr_en & full & !rd_en): data is dropped, overflow is set, and state is unchanged.
  - Rejected read (rd_en & empty): underflow is set; pointers and rd_data are unchanged.
- count:
  - count += 1 on an accepted write only.
  - count -= 1 on an accepted read only.
  - count is unchanged when both or neither are accepted.
  - count never leaves 0..DEPTH.
- Flags:
  - All flags are recomputed from the post-edge count.
  - Thresholds compare with count at width ADDR_WIDTH+1.
- flush:
  - Pointers go to 0, count = 0, and empty = 1 after the edge.
  - Any wr_en and rd_en in the same cycle are ignored and do not set error flags.
  - Sticky flags are preserved.
  - rd_data is don't-care while empty.
- clr_err:
  - Clears overflow and underflow at the edge.
  - If a new error event occurs in the same cycle, set wins.

Test Plan:
1. Reset, then idle 3 cycles -> count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
2. Write 0xA5 with the FIFO empty -> the next cycle shows empty = 0, rd_data = 0xA5, count = 1. Then rd_en for 1 cycle -> empty = 1, count = 0.
3. Write 0x00..0x0F (16 words) -> after the 12th write almost_full = 1; after the 16th, full = 1 and count = 16. A 17th write of 0xFF -> overflow = 1 and count = 16. Read all 16 -> the data order is 0x00..0x0F with 0xFF absent, and almost_empty asserts when count = 2.
4. Full FIFO, wr_en & rd_en with 0x77 -> count stays 16 and rd_data advances to the next word. Drain -> 0x77 is the last word, confirming tail insertion and pointer wrap.
5. Empty FIFO, rd_en & wr_en with 0x3C -> underflow = 1, count = 1, rd_data = 0x3C. Then clr_err -> underflow = 0. clr_err together with rd_en on empty -> underflow stays 1.
6. Load 5 words, then flush together with wr_en = 1 -> count = 0, empty = 1, overflow unchanged. Load 3 words, then assert RST mid-stream -> all outputs return to their reset values.
